// File: rtl/avg_rmw_ctrl_pkg.sv
// Shared definitions for the averaging read-modify-write sequencer:
// FSM states, frame-store pixel word layout and drop counter limit.
package avg_rmw_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT_RD,
    ST_AVG,
    ST_WRITE
  } state_t;

  // Pixel word: {1'b0, R[14:10], G[9:5], B[4:0]}
  localparam int unsigned R_LSB = 10;
  localparam int unsigned G_LSB = 5;
  localparam int unsigned B_LSB = 0;
  localparam logic [15:0] PIX_MASK = 16'h7FFF;
  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  function automatic logic [15:0] pack_pixel(input logic [4:0] r,
                                             input logic [4:0] g,
                                             input logic [4:0] b);
    logic [15:0] w;
    w = '0;
    w[R_LSB +: 5] = r;
    w[G_LSB +: 5] = g;
    w[B_LSB +: 5] = b;
    return w;
  endfunction

endpackage

// File: rtl/avg_rmw_ctrl.sv
// Read-modify-write sequencer: reads the running sum for a pixel, presents it
// to the external averager and writes the filtered word back to the frame store.
module avg_rmw_ctrl
  import avg_rmw_ctrl_pkg::*;
#(
  parameter int ADDR_W = 18
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iDVAL,
  input  logic [4:0]        iRed,
  input  logic [4:0]        iGreen,
  input  logic [4:0]        iBlue,
  input  logic [ADDR_W-1:0] iADDR,
  input  logic              iSEED,
  output logic              oREADY,
  output logic [ADDR_W-1:0] oMEM_ADDR,
  output logic              oMEM_RD,
  output logic              oMEM_WR,
  output logic [15:0]       oMEM_WDATA,
  input  logic              iMEM_WAIT,
  input  logic [15:0]       iMEM_RDATA,
  input  logic              iMEM_RDVAL,
  output logic [4:0]        oAVG_RED,
  output logic [4:0]        oAVG_GREEN,
  output logic [4:0]        oAVG_BLUE,
  output logic [15:0]       oAVG_OLD,
  input  logic [15:0]       iAVG_NEW,
  output logic [15:0]       oDROP_CNT
);

  state_t state, state_nxt;
  logic   accept;
  logic   drop;

  // oREADY is a registered copy of "next state is IDLE", so it alone decides acceptance.
  assign accept = iDVAL & oREADY;
  assign drop   = iDVAL & ~oREADY;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (accept) state_nxt = iSEED ? ST_WRITE : ST_READ;
      ST_READ:    if (!iMEM_WAIT) state_nxt = ST_WAIT_RD;
      ST_WAIT_RD: if (iMEM_RDVAL) state_nxt = ST_AVG;
      ST_AVG:     state_nxt = ST_WRITE;
      ST_WRITE:   if (!iMEM_WAIT) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state   <= ST_IDLE;
      oREADY  <= 1'b0;
      oMEM_RD <= 1'b0;
      oMEM_WR <= 1'b0;
    end else begin
      state   <= state_nxt;
      oREADY  <= (state_nxt == ST_IDLE);
      oMEM_RD <= (state_nxt == ST_READ);
      oMEM_WR <= (state_nxt == ST_WRITE);
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oMEM_ADDR  <= '0;
      oMEM_WDATA <= '0;
      oAVG_RED   <= '0;
      oAVG_GREEN <= '0;
      oAVG_BLUE  <= '0;
      oAVG_OLD   <= '0;
    end else begin
      if (accept) begin
        oMEM_ADDR  <= iADDR;
        oAVG_RED   <= iRed;
        oAVG_GREEN <= iGreen;
        oAVG_BLUE  <= iBlue;
        if (iSEED) oMEM_WDATA <= pack_pixel(iRed, iGreen, iBlue);
      end
      if (state == ST_WAIT_RD && iMEM_RDVAL) oAVG_OLD <= iMEM_RDATA;
      if (state == ST_AVG) oMEM_WDATA <= iAVG_NEW & PIX_MASK;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oDROP_CNT <= '0;
    end else if (drop && oDROP_CNT != DROP_MAX) begin
      oDROP_CNT <= oDROP_CNT + 16'd1;
    end
  end

endmodule

// File: doc/avg_rmw_ctrl.md
# avg_rmw_ctrl

Read-modify-write sequencer that feeds the frame `averager` low-pass filter and writes its result back to the frame store. It accepts 5-5-5 RGB pixel strobes from the camera path and reads the saved 16-bit running sum at the pixel's address. It presents new pixel plus old sum to `averager`, captures `oNew`, and writes it back to the same address. Camera pixels cannot stall, so pixels arriving while a transaction is in flight are dropped and counted.

## Interface
- `ADDR_W`, 18: frame-store word address width.
- `iCLK` input 1: sole clock; all logic rising-edge.
- `iRST_N` input 1: reset, asynchronous, active-low.
- `iDVAL` input 1: pixel strobe, one cycle per pixel.
- `iRed`, `iGreen`, `iBlue` input 5 each: pixel colour.
- `iADDR` input ADDR_W: pixel word address.
- `iSEED` input 1: write raw pixel instead of averaging (first frame).
- `oREADY` output 1: high when a strobe this cycle will be accepted.
- `oMEM_ADDR` output ADDR_W: frame-store address.
- `oMEM_RD` output 1: read request.
- `oMEM_WR` output 1: write request.
- `oMEM_WDATA` output 16: write data, {1'b0,R,G,B}.
- `iMEM_WAIT` input 1: frame store stall; request held while high.
- `iMEM_RDATA` input 16: read data.
- `iMEM_RDVAL` input 1: `iMEM_RDATA` valid this cycle.
- `oAVG_RED`, `oAVG_GREEN`, `oAVG_BLUE` output 5 each: to `averager` colour inputs.
- `oAVG_OLD` output 16: to `averager` `iOld`.
- `iAVG_NEW` input 16: from `averager` `oNew`.
- `oDROP_CNT` output 16: saturating count of dropped strobes.

## Operation
- States: IDLE, READ, WAIT_RD, AVG, WRITE.
- IDLE: `oREADY`=1.
  - If `iDVAL`: register pixel, address and seed.
  - If seed: go to WRITE with `oMEM_WDATA`={1'b0,R,G,B}.
  - Else: go to READ.
- READ: `oMEM_RD`=1 and `oMEM_ADDR` held. Leave on the first cycle with `iMEM_WAIT`=0, going to WAIT_RD.
- WAIT_RD: wait for `iMEM_RDVAL`. On it, register `iMEM_RDATA` into `oAVG_OLD` and go to AVG.
- AVG: `averager` output settles. At end of cycle, capture `iAVG_NEW` into `oMEM_WDATA` with bit 15 forced to 0. Go to WRITE.
- WRITE: `oMEM_WR`=1. Leave on the first cycle with `iMEM_WAIT`=0, going to IDLE.
- `oAVG_*` colour outputs are driven from the registered pixel; they are stable from accept until the next accept.
- `iDVAL` while `oREADY`=0: the pixel is discarded and `oDROP_CNT` increments, saturating at 0xFFFF.
- `iMEM_RDVAL` outside WAIT_RD: ignored.
- `iMEM_RDVAL` in the same cycle the READ request completes: not possible. The frame store guarantees at least one cycle of read latency.
- `oMEM_RD` and `oMEM_WR` are never high together.
- Reset value of every output is 0; `oREADY` is 1 on the first cycle after reset release.
- Reset mid-transaction returns the block to IDLE. It abandons the pixel, clears all requests, and clears `oDROP_CNT`.
  - If reset lands in READ, WAIT_RD or AVG, the stored word is unchanged.
  - If reset lands in WRITE, the stored word is undefined.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Accept in cycle N.
  - Averaging path, no stalls: `oMEM_RD` high in N+1, returns to IDLE after WRITE.
  - Averaging path, read latency L: read data in cycle N+1+L, AVG in N+2+L, `oMEM_WR` high in N+3+L, `oREADY` back in N+4+L.
  - Seed path: `oMEM_WR` high in N+1, `oREADY` in N+2.
- Each cycle of `iMEM_WAIT`=1 in READ or WRITE extends the transaction by one cycle. `oMEM_ADDR` and `oMEM_WDATA` are held stable throughout.
- `averager` is combinational. `oAVG_OLD` and the `oAVG_*` colours are stable for the full AVG cycle.

## Structure
- Shared package holds:
  - the state enumeration;
  - pixel-word pack constants: R at [14:10], G at [9:5], B at [4:0], bit 15 reserved 0;
  - `DROP_MAX`=16'hFFFF.
- No sub-module inside this block. The parent instantiates `averager` beside it and wires `oAVG_*`/`iAVG_NEW`.
- The bench instantiates both this block and `averager` (n=2) plus a behavioural frame store with configurable latency and wait insertion.

## Test plan
- Seed write: `iSEED`=1, R=31, G=0, B=16, addr 0x00010 -> one write to 0x00010 of 0x7C10, no read, `oREADY` after 2 cycles.
- Average: memory holds 0x7C10 at 0x00010, pixel 0/0/0 with `iSEED`=0 -> read 0x00010 then write 0x600C (R=24, G=0, B=12).
- Wait states: `iMEM_WAIT` high 3 cycles during READ and 2 during WRITE -> `oMEM_RD` high 4 cycles and `oMEM_WR` high 3, address and data stable, final word correct.
- Drops: strobes on 3 consecutive cycles, latency 2 -> first pixel processed, `oDROP_CNT`=2. With the counter preloaded near 0xFFFF by a long burst -> holds at 0xFFFF.
- Reset in WAIT_RD: assert `iRST_N`=0 while waiting, release -> all outputs 0, `oREADY`=1, late `iMEM_RDVAL` ignored, memory word unchanged.
- Stray `iMEM_RDVAL` in IDLE with data 0xFFFF -> `oAVG_OLD` unchanged, no write.
